fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch front end. It is the producer side of the IF/ID interface: it drives pcF, instrF and PCPlus4F into the IF/ID pipeline register.
- Generates sequential PCs and issues pipelined requests to instruction memory over a valid/ready request channel plus an in-order response channel.
- Buffers returned instructions in a small FIFO. Honours IFIDWrite (stall) and execute-stage redirects, discarding wrong-path responses.

Parameters:
- DATA_WIDTH, 32: address and instruction width.
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- FIFO_DEPTH, 4: instruction buffer entries. Must be a power of 2 and ≥2. Also the credit limit on outstanding requests.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- IFIDWrite  in  1  IF/ID accepts the presented instruction this cycle (0 = stall).
- redirectE  in  1  taken branch/jump resolved in execute.
- PCTargetE  in  DATA_WIDTH  redirect target.
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  DATA_WIDTH  word-aligned fetch address.
- imem_rsp_valid  in  1  response valid. In order, no backpressure.
- imem_rsp_data  in  DATA_WIDTH  instruction word.
- validF  out  1  pcF/instrF/PCPlus4F hold a real instruction.
- pcF  out  DATA_WIDTH  PC of the presented instruction.
- instrF  out  DATA_WIDTH  presented instruction.
- PCPlus4F  out  DATA_WIDTH  pcF+4, modulo 2^DATA_WIDTH.

Behaviour:
- Reset (async, rst_n=0):
  - reqPC=RESET_PC; FIFO empty; outstanding=0; drop=0.
  - imem_req_valid=0, validF=0, instrF=32'h00000013 (NOP), pcF=0, PCPlus4F=4.
- Request issue:
  - imem_req_valid=1 iff rst_n=1 && !redirectE && (outstanding + fifo_count) < FIFO_DEPTH.
  - imem_req_addr = {reqPC[DATA_WIDTH-1:2],2'b00}.
  - On valid&&ready: reqPC += 4 (wraps), outstanding++.
  - imem_req_addr must stay stable while valid && !ready.
- Response:
  - Each rsp_valid decrements outstanding.
  - If drop>0: drop--, data discarded.
  - Else push {pc, instr} into the FIFO. The pc tag comes from an internal tag PC register that advances by 4 per push.
  - Overflow is impossible by credit rule. The bench asserts it never occurs.
- Output:
  - FIFO non-empty: validF=1 and head entry presented.
  - FIFO empty: validF=0, instrF=NOP, pcF/PCPlus4F hold last value.
  - Pop when validF && IFIDWrite && !redirectE.
  - IFIDWrite=0 holds the head unchanged for any number of cycles.
- Redirect (redirectE=1, single cycle, highest priority):
  - reqPC and tag PC <= {PCTargetE[DATA_WIDTH-1:2],2'b00}.
  - FIFO flushed; no pop; no request issued that cycle.
  - drop <= outstanding after this cycle's decrement. A response arriving in the redirect cycle is itself dropped.
  - Next cycle validF=0 and requests resume from the target.
- Back-to-back redirects: the latest target wins; drop accumulates correctly.
- Counters are $clog2(FIFO_DEPTH)+1 bits. outstanding never exceeds FIFO_DEPTH.
- Reset mid-operation: all state cleared immediately. Late responses after reset are ignored (rsp_valid with outstanding=0 is a protocol error; bench assertion).

Optional Feature:
- Macro FETCH_BYPASS_EN.
- Defined: when the FIFO is empty and an accepted, non-dropped response arrives, it is presented combinationally the same cycle (validF=1). If IFIDWrite=1 it is consumed without being written to the FIFO.
- Undefined: a response is always written to the FIFO and is visible the cycle after arrival (1-cycle minimum response-to-validF latency).

Decomposition:
- fetch_pkg:
  - NOP_INSTR = 32'h00000013.
  - fetch_entry_t struct {pc, instr}.
  - PC_INCR = 4.
- Sub-module fetch_fifo: parameterised synchronous FIFO of fetch_entry_t with push, pop, flush, count, empty and full.
- fetch_unit holds the PC, credit/drop counters and output muxing.

Test Plan:
- Reset release, ready=1, memory latency 1, IFIDWrite=1 → addresses 0,4,8,C… issued. validF rises 2 cycles after the first request (1 with bypass). pcF sequence 0,4,8 with PCPlus4F 4,8,C.
- IFIDWrite=0 for 10 cycles → head held (pcF=0x0 stable); at most 4 requests outstanding+buffered; imem_req_valid drops to 0.
- Redirect to 0x100 with 2 outstanding → both responses discarded; next validF shows pcF=0x100, instr = mem[0x100].
- Redirect with PCTargetE=0x103 → fetch resumes at 0x100.
- imem_req_ready toggling 1,0,0,1 → address held stable while stalled; no duplicate or skipped PC.
- Assert rst_n low mid-stream with FIFO full → outputs immediately reset (validF=0, instrF=0x13); fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int          FETCH_XLEN = 32;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam int          PC_INCR    = 4;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {pc, instr} entries with flush and an
// unregistered head so the IF/ID register sees the oldest entry directly.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  entry_t                 wdata_i,
  output entry_t                 rdata_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o,
  output logic                   full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !flush_i && !empty_o;
  assign do_push = push_i && !flush_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: credit-limited sequential requests, in-order
// responses buffered for IF/ID, redirect flush with wrong-path drop counting.
// Optional same-cycle response bypass when FETCH_BYPASS_EN is defined.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
  parameter int                    FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  IFIDWrite,
  input  logic                  redirectE,
  input  logic [DATA_WIDTH-1:0] PCTargetE,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [DATA_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  output logic                  validF,
  output logic [DATA_WIDTH-1:0] pcF,
  output logic [DATA_WIDTH-1:0] instrF,
  output logic [DATA_WIDTH-1:0] PCPlus4F
);

  localparam int                    CW         = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);
  localparam logic [DATA_WIDTH-1:0] INCR       = DATA_WIDTH'(PC_INCR);
  localparam logic [DATA_WIDTH-1:0] NOP        = DATA_WIDTH'(NOP_INSTR);
  localparam logic [CW:0]           DEPTH_W    = (CW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] instr;
  } entry_t;

  logic [DATA_WIDTH-1:0] req_pc_q, req_pc_d;
  logic [DATA_WIDTH-1:0] tag_pc_q, tag_pc_d;
  logic [DATA_WIDTH-1:0] pc_hold_q, pc_hold_d;
  logic [CW-1:0]         out_q, out_d;
  logic [CW-1:0]         drop_q, drop_d;
  logic [CW-1:0]         out_after_rsp;

  logic          rsp_live, rsp_keep, bypass, take, req_fire, credit_ok;
  logic          fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [CW-1:0] fifo_count;
  entry_t        fifo_wdata, fifo_head, head;

  // A response with nothing outstanding (e.g. a late one after reset) is ignored.
  assign rsp_live = imem_rsp_valid && (out_q != '0);
  assign rsp_keep = rsp_live && (drop_q == '0) && !redirectE;

`ifdef FETCH_BYPASS_EN
  assign bypass = fifo_empty && rsp_keep;
`else
  assign bypass = 1'b0;
`endif

  assign credit_ok      = ({1'b0, out_q} + {1'b0, fifo_count}) < DEPTH_W;
  assign imem_req_valid = rst_n && !redirectE && credit_ok && !fifo_full;
  assign imem_req_addr  = req_pc_q & ALIGN_MASK;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign validF   = !fifo_empty || bypass;
  assign take     = validF && IFIDWrite && !redirectE;
  assign fifo_pop = take && !bypass;
  assign fifo_push = rsp_keep && !(bypass && IFIDWrite);
  assign fifo_wdata = '{pc: tag_pc_q, instr: imem_rsp_data};

  always_comb begin
    head = fifo_head;
    if (bypass) head = fifo_wdata;
  end

  assign pcF      = validF ? head.pc    : pc_hold_q;
  assign instrF   = validF ? head.instr : NOP;
  assign PCPlus4F = pcF + INCR;

  assign out_after_rsp = out_q - CW'(rsp_live);

  always_comb begin
    req_pc_d  = req_pc_q;
    tag_pc_d  = tag_pc_q;
    drop_d    = drop_q;
    pc_hold_d = pcF;
    out_d     = out_after_rsp + CW'(req_fire);
    if (req_fire)                      req_pc_d = req_pc_q + INCR;
    if (rsp_keep)                      tag_pc_d = tag_pc_q + INCR;
    if (rsp_live && (drop_q != '0))    drop_d   = drop_q - CW'(1);
    // Everything still in flight after this cycle belongs to the wrong path.
    if (redirectE) begin
      req_pc_d = PCTargetE & ALIGN_MASK;
      tag_pc_d = PCTargetE & ALIGN_MASK;
      drop_d   = out_after_rsp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_pc_q  <= RESET_PC;
      tag_pc_q  <= RESET_PC & ALIGN_MASK;
      pc_hold_q <= '0;
      out_q     <= '0;
      drop_q    <= '0;
    end else begin
      req_pc_q  <= req_pc_d;
      tag_pc_q  <= tag_pc_d;
      pc_hold_q <= pc_hold_d;
      out_q     <= out_d;
      drop_q    <= drop_d;
    end
  end

  fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .flush_i (redirectE),
    .wdata_i (fifo_wdata),
    .rdata_o (fifo_head),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a variable-latency in-order memory model.
`timescale 1ns/1ps
module tb_fetch_unit;

`ifdef FETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        IFIDWrite = 1'b0;
  logic        redirectE = 1'b0;
  logic [31:0] PCTargetE = 32'h0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        validF;
  logic [31:0] pcF, instrF, PCPlus4F;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .IFIDWrite      (IFIDWrite),
    .redirectE      (redirectE),
    .PCTargetE      (PCTargetE),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .validF         (validF),
    .pcF            (pcF),
    .instrF         (instrF),
    .PCPlus4F       (PCPlus4F)
  );

  typedef struct {
    logic [31:0] addr;
    int          age;
  } mreq_t;

  typedef struct {
    logic        ifid;
    logic        exp_rv;
    logic [31:0] exp_addr;
    logic        exp_vf;
    logic [31:0] exp_pc;
  } vec_t;

  mreq_t mq[$];
  int    mem_lat = 1;
  int    tb_out = 0, tb_buf = 0, tb_drop = 0;
  int    n_checks = 0, n_fail = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5C3_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  // Drive one cycle's inputs (including the memory response) and let outputs settle.
  task automatic prep(input logic ifid, input logic redir, input logic [31:0] tgt, input logic rdy);
    @(negedge clk);
    IFIDWrite      = ifid;
    redirectE      = redir;
    PCTargetE      = tgt;
    imem_req_ready = rdy;
    imem_rsp_valid = (mq.size() > 0) && (mq[0].age == 0);
    imem_rsp_data  = imem_rsp_valid ? mem_word(mq[0].addr) : 32'h0;
    #1;
  endtask

  // Update the memory and credit models from this cycle's handshakes, then clock.
  task automatic adv();
    logic fire, rsp;
    fire = imem_req_valid && imem_req_ready;
    rsp  = imem_rsp_valid;
    n_checks++;
    if (rsp && tb_out == 0) begin
      n_fail++;
      $display("FAIL rsp_without_outstanding: got rsp_valid=1 expected none outstanding=%0d", tb_out);
    end
    if (redirectE) begin
      tb_drop = tb_out - int'(rsp);
      tb_buf  = 0;
    end else begin
      if (rsp) begin
        if (tb_drop > 0) tb_drop--;
        else             tb_buf++;
      end
      if (validF && IFIDWrite) tb_buf--;
    end
    tb_out = tb_out - int'(rsp) + int'(fire);
    n_checks++;
    if (tb_out + tb_buf > 4 || tb_buf > 4) begin
      n_fail++;
      $display("FAIL credit_overflow: got outstanding=%0d buffered=%0d expected sum<=4", tb_out, tb_buf);
    end
    if (rsp) void'(mq.pop_front());
    foreach (mq[i]) if (mq[i].age > 0) mq[i].age--;
    if (fire) mq.push_back('{imem_req_addr, mem_lat - 1});
    @(posedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_valid"}, 32'(imem_req_valid), 32'h0);
    check({tag, "_validF"},    32'(validF),         32'h0);
    check({tag, "_instrF"},    instrF,              32'h13);
    check({tag, "_pcF"},       pcF,                 32'h0);
    check({tag, "_PCPlus4F"},  PCPlus4F,            32'h4);
  endtask

  // Consume n consecutive instructions starting at pc start within a cycle budget.
  task automatic expect_stream(input string name, input logic [31:0] start, input int n, input int budget);
    logic [31:0] exp;
    int seen;
    exp  = start;
    seen = 0;
    for (int t = 0; t < budget && seen < n; t++) begin
      prep(1'b1, 1'b0, 32'h0, 1'b1);
      if (validF) begin
        check({name, "_pcF"},      pcF,      exp);
        check({name, "_instrF"},   instrF,   mem_word(exp));
        check({name, "_PCPlus4F"}, PCPlus4F, exp + 32'd4);
        exp += 32'd4;
        seen++;
      end
      adv();
    end
    if (seen < n) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d instructions expected %0d", name, seen, n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[8];
    logic        rdy_pat[12];
    logic [31:0] pc0, exp_addr, exp_pc;
    int          seen;

    for (int k = 0; k < 8; k++)
      tbl[k] = '{1'b1, 1'b1, 32'(4 * k), (k >= LAT), (k >= LAT) ? 32'(4 * (k - LAT)) : 32'h0};
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    // Reset state
    for (int i = 0; i < 2; i++) begin
      prep(1'b1, 1'b0, 32'h0, 1'b1);
      check_reset_outputs("reset");
      adv();
    end
    #2 rst_n = 1'b1;

    // Sequential fetch after reset release, latency 1
    for (int k = 0; k < 8; k++) begin
      prep(tbl[k].ifid, 1'b0, 32'h0, 1'b1);
      check("seq_req_valid", 32'(imem_req_valid), 32'(tbl[k].exp_rv));
      if (tbl[k].exp_rv) check("seq_req_addr", imem_req_addr, tbl[k].exp_addr);
      check("seq_validF",   32'(validF), 32'(tbl[k].exp_vf));
      check("seq_pcF",      pcF,         tbl[k].exp_pc);
      check("seq_PCPlus4F", PCPlus4F,    tbl[k].exp_pc + 32'd4);
      check("seq_instrF",   instrF,      tbl[k].exp_vf ? mem_word(tbl[k].exp_pc) : 32'h13);
      adv();
    end

    // Stall for 10 cycles: head held, requests stop once credits are used up
    pc0 = 32'(4 * (8 - LAT));
    for (int s = 0; s < 10; s++) begin
      prep(1'b0, 1'b0, 32'h0, 1'b1);
      check("stall_validF", 32'(validF), 32'h1);
      check("stall_pcF",    pcF,         pc0);
      if (s == 9) check("stall_req_valid", 32'(imem_req_valid), 32'h0);
      adv();
    end
    expect_stream("resume", pc0, 6, 10);

    // Redirect to 0x100 with at least two requests outstanding (latency 3)
    mem_lat = 3;
    for (int t = 0; t < 12; t++) begin
      if (t >= 4 && mq.size() >= 2) break;
      prep(1'b1, 1'b0, 32'h0, 1'b1);
      adv();
    end
    prep(1'b1, 1'b1, 32'h100, 1'b1);
    check("redir_req_valid", 32'(imem_req_valid), 32'h0);
    adv();
    prep(1'b1, 1'b0, 32'h0, 1'b1);
    check("redir_bubble_validF", 32'(validF), 32'h0);
    check("redir_req_addr",      imem_req_addr, 32'h100);
    adv();
    expect_stream("redir100", 32'h100, 3, 30);

    // Back-to-back redirects, last one unaligned: latest target wins, aligned
    prep(1'b1, 1'b1, 32'h200, 1'b1);
    adv();
    prep(1'b1, 1'b1, 32'h103, 1'b1);
    adv();
    prep(1'b1, 1'b0, 32'h0, 1'b1);
    check("b2b_req_addr", imem_req_addr, 32'h100);
    check("b2b_validF",   32'(validF),   32'h0);
    adv();
    expect_stream("b2b", 32'h100, 3, 30);

    // Request-ready toggling: address held while stalled, no skipped/duplicated PCs
    mem_lat = 1;
    prep(1'b1, 1'b1, 32'h40, 1'b1);
    adv();
    exp_addr = 32'h40;
    exp_pc   = 32'h40;
    seen     = 0;
    for (int i = 0; i < 12; i++) begin
      prep(1'b1, 1'b0, 32'h0, rdy_pat[i]);
      if (imem_req_valid) begin
        check("ready_toggle_addr", imem_req_addr, exp_addr);
        if (rdy_pat[i]) exp_addr += 32'd4;
      end
      if (validF) begin
        check("ready_toggle_pcF",    pcF,    exp_pc);
        check("ready_toggle_instrF", instrF, mem_word(exp_pc));
        exp_pc += 32'd4;
        seen++;
      end
      adv();
    end
    check("ready_toggle_progress", 32'(seen >= 4), 32'h1);

    // Fill the FIFO, then reset mid-stream
    for (int i = 0; i < 8; i++) begin
      prep(1'b0, 1'b0, 32'h0, 1'b1);
      adv();
    end
    prep(1'b0, 1'b0, 32'h0, 1'b1);
    check("full_req_valid", 32'(imem_req_valid), 32'h0);
    check("full_validF",    32'(validF),         32'h1);
    rst_n = 1'b0;
    imem_rsp_valid = 1'b0;
    mq.delete();
    tb_out  = 0;
    tb_buf  = 0;
    tb_drop = 0;
    #1;
    check_reset_outputs("midreset");
    @(posedge clk);
    #2 rst_n = 1'b1;
    prep(1'b1, 1'b0, 32'h0, 1'b1);
    check("restart_req_valid", 32'(imem_req_valid), 32'h1);
    check("restart_req_addr",  imem_req_addr,       32'h0);
    check("restart_validF",    32'(validF),         32'h0);
    adv();
    expect_stream("restart", 32'h0, 4, 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
